stack_rpn_sequencer: RTL and testbench
======================================

// Module: stack_rpn_sequencer
// PURPOSE
//  Command sequencer directly upstream of the 5-entry, 4-bit structural stack.
//  Accepts RPN tokens (literal / operator) on a valid/ready port.
//  Drives the stack's COMMAND/INDEX/I_DATA and reads back O_DATA.
//  Tracks stack depth itself, so overflow, underflow and bad-index are caught
//  before the stack's modulo-5 pointer wraps silently.
// PARAMETERS
//  DEPTH  5  stack capacity; must equal the stack's entry count
//  DW     4  data width; must equal stack I_DATA/O_DATA width
// PORTS
//  CLK        in   1   single clock, rising edge
//  RESET      in   1   synchronous, active-high; shared with the stack instance
//  TOK_VALID  in   1   token present
//  TOK_READY  out  1   sequencer can accept a token
//  TOK_OP     in   3   000 LIT, 001 ADD, 010 SUB, 011 AND, 100 XOR, 101 DUP, 110 PEEK, 111 DROP
//  TOK_DATA   in   DW  literal value (LIT only)
//  TOK_IDX    in   3   depth index from top, 0 = top (PEEK only)
//  COMMAND    out  2   to stack: 00 nop, 01 push, 10 pop, 11 get
//  INDEX      out  3   to stack INDEX
//  I_DATA     out  DW  to stack I_DATA
//  O_DATA     in   DW  from stack; valid in the same cycle as a pop or get command
//  RES_VALID  out  1   one-cycle pulse: operation finished
//  RES_DATA   out  DW  pushed result, or peeked/dropped value
//  ERR        out  2   valid with RES_VALID: 00 ok, 01 overflow, 10 underflow, 11 bad index
//  DEPTH_O    out  3   current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset values: COMMAND=00, INDEX=0, I_DATA=0, RES_VALID=0, RES_DATA=0,
//    ERR=00, DEPTH_O=0, TOK_READY=1; FSM enters IDLE.
//  Reset mid-operation: abort immediately. No partial command follows reset.
//  FSM states and TOK_READY:
//    IDLE, POP_B, POP_A, PUSH_R, PUSH_L, GET, DONE.
//    TOK_READY=1 only in IDLE. Accept = TOK_VALID & TOK_READY.
//  Legality check at accept, against DEPTH_O:
//    LIT needs depth<DEPTH (else 01).
//    ADD/SUB/AND/XOR need depth>=2 (else 10).
//    DUP needs 1<=depth<DEPTH (else 10 or 01; underflow has priority).
//    DROP needs depth>=1 (else 10).
//    PEEK needs TOK_IDX<depth (else 11).
//    Illegal token: go to DONE, issue no stack command, pulse RES_VALID with ERR.
//  Command sequences (one stack command per cycle, COMMAND=00 in IDLE/DONE):
//    LIT:    PUSH_L (push TOK_DATA) -> DONE.
//    binary: POP_B (capture b) -> POP_A (capture a) -> PUSH_R (push a op b) -> DONE.
//      Captures take O_DATA at the closing edge of the pop cycle.
//    DUP:    GET with INDEX=0 (capture) -> PUSH_R (push captured value) -> DONE.
//    PEEK:   GET with INDEX=TOK_IDX (capture) -> DONE. Depth unchanged.
//    DROP:   POP_B (capture) -> DONE.
//  DONE: RES_VALID=1 for exactly one cycle, then IDLE.
//  Latency from accept edge to RES_VALID: LIT 2, binary 4, DUP 3, PEEK 2, DROP 2, error 1.
//  Depth counter: +1 on each push cycle, -1 on each pop cycle; never leaves 0..DEPTH.
//  Arithmetic: DW-bit results. ADD/SUB wrap mod 2^DW. SUB is a - b (a = deeper operand).
//  Back-to-back tokens: a new token may be accepted the cycle after DONE.
// CONFIGURATION
//  STACK_RPN_SAT_EN defined: ADD clamps to 2^DW-1 and SUB clamps to 0 (unsigned).
//    On a clamp, ERR=00 and RES_DATA holds the clamped value.
//  STACK_RPN_SAT_EN undefined: ADD/SUB wrap modulo 2^DW. Logic and FSM otherwise identical.
// STRUCTURE
//  Package stack_rpn_pkg:
//    stack command codes, TOK_OP opcode enum, FSM state enum, ERR codes.
//    DEPTH/DW defaults.
//  Sub-module stack_rpn_alu:
//    combinational a,b,op -> DW-bit result; holds the STACK_RPN_SAT_EN clamp.
//  Top level: FSM, depth counter, operand registers.
// TESTING
//  Bench pairs the sequencer with the real stack; a reference model predicts contents.
//  1. LIT 3, LIT 9, ADD -> pushes 3, 9, then pops 9 and 3, push 12.
//     Final RES_DATA=12, ERR=00, DEPTH_O=1.
//  2. LIT 2, LIT 5, SUB -> RES_DATA=13 (wrap).
//     With STACK_RPN_SAT_EN: RES_DATA=0.
//  3. Five LITs (1..5), then a sixth LIT -> DEPTH_O=5, ERR=01, no push issued.
//     Then PEEK idx 4 -> RES_DATA=1.
//  4. From reset, ADD -> ERR=10, COMMAND stays 00, DEPTH_O=0.
//     Then DROP -> ERR=10.
//  5. LIT 7, DUP, PEEK idx 1 -> RES_DATA=7, DEPTH_O=2.
//     Then PEEK idx 2 -> ERR=11.
//  6. RESET asserted during POP_A of an XOR -> next cycle all outputs at reset values.
//     DEPTH_O=0, TOK_READY=1, no push follows.

Source files
------------

// File: rtl/stack_rpn_pkg.sv
// Shared types for the RPN command sequencer: stack command codes, token opcodes,
// FSM states, error codes and default geometry.
package stack_rpn_pkg;

  localparam int DEPTH_DEF = 5;
  localparam int DW_DEF    = 4;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    OP_LIT  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_DUP  = 3'b101,
    OP_PEEK = 3'b110,
    OP_DROP = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP_B,
    ST_POP_A,
    ST_PUSH_R,
    ST_PUSH_L,
    ST_GET,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_OVER  = 2'b01,
    ERR_UNDER = 2'b10,
    ERR_IDX   = 2'b11
  } err_e;

endpackage

// File: rtl/stack_rpn_alu.sv
// Combinational RPN operator: res = a op b (a is the deeper operand); non-arithmetic ops pass a.
// STACK_RPN_SAT_EN defined: ADD clamps to all-ones, SUB clamps to zero; otherwise both wrap.
module stack_rpn_alu
  import stack_rpn_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  op_e           op,
  output logic [DW-1:0] res
);

`ifdef STACK_RPN_SAT_EN
  logic [DW:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
`endif

  always_comb begin
    res = a;
    case (op)
`ifdef STACK_RPN_SAT_EN
      OP_ADD:  res = sum[DW] ? '1 : sum[DW-1:0];
      OP_SUB:  res = (a < b) ? '0 : a - b;
`else
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
`endif
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/stack_rpn_sequencer.sv
// RPN token sequencer driving a DEPTH-entry stack; tracks depth to flag overflow/underflow/bad index.
// Latency accept->RES_VALID: LIT/PEEK/DROP 2, binary 4, DUP 3, error 1; TOK_READY only in IDLE.
module stack_rpn_sequencer
  import stack_rpn_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          TOK_VALID,
  output logic          TOK_READY,
  input  logic [2:0]    TOK_OP,
  input  logic [DW-1:0] TOK_DATA,
  input  logic [2:0]    TOK_IDX,
  output logic [1:0]    COMMAND,
  output logic [2:0]    INDEX,
  output logic [DW-1:0] I_DATA,
  input  logic [DW-1:0] O_DATA,
  output logic          RES_VALID,
  output logic [DW-1:0] RES_DATA,
  output logic [1:0]    ERR,
  output logic [2:0]    DEPTH_O
);

  state_e        state_q, state_d;
  op_e           op_q, tok_op;
  err_e          err_q, chk_err;
  logic [2:0]    idx_q;
  logic [2:0]    depth_q;
  logic [DW-1:0] a_q, b_q, res_q, alu_res;
  logic          accept;

  assign tok_op    = op_e'(TOK_OP);
  assign TOK_READY = (state_q == ST_IDLE);
  assign accept    = TOK_VALID & TOK_READY;
  assign RES_VALID = (state_q == ST_DONE);
  assign RES_DATA  = res_q;
  assign ERR       = err_q;
  assign DEPTH_O   = depth_q;

  // LIT parks its literal in a_q and DUP captures into a_q, so the ALU pass-through pushes both.
  stack_rpn_alu #(.DW(DW)) u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (alu_res)
  );

  always_comb begin
    chk_err = ERR_OK;
    case (tok_op)
      OP_LIT:  if (int'(depth_q) >= DEPTH) chk_err = ERR_OVER;
      OP_DUP: begin
        if (depth_q == 3'd0)              chk_err = ERR_UNDER;
        else if (int'(depth_q) >= DEPTH)  chk_err = ERR_OVER;
      end
      OP_PEEK: if (TOK_IDX >= depth_q)    chk_err = ERR_IDX;
      OP_DROP: if (depth_q == 3'd0)       chk_err = ERR_UNDER;
      default: if (depth_q < 3'd2)        chk_err = ERR_UNDER;
    endcase
  end

  always_comb begin
    state_d = state_q;
    COMMAND = CMD_NOP;
    INDEX   = '0;
    I_DATA  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (chk_err != ERR_OK)                        state_d = ST_DONE;
          else if (tok_op == OP_LIT)                    state_d = ST_PUSH_L;
          else if (tok_op == OP_DUP || tok_op == OP_PEEK) state_d = ST_GET;
          else                                          state_d = ST_POP_B;
        end
      end
      ST_POP_B: begin
        COMMAND = CMD_POP;
        state_d = (op_q == OP_DROP) ? ST_DONE : ST_POP_A;
      end
      ST_POP_A: begin
        COMMAND = CMD_POP;
        state_d = ST_PUSH_R;
      end
      ST_PUSH_R, ST_PUSH_L: begin
        COMMAND = CMD_PUSH;
        I_DATA  = alu_res;
        state_d = ST_DONE;
      end
      ST_GET: begin
        COMMAND = CMD_GET;
        INDEX   = (op_q == OP_PEEK) ? idx_q : 3'd0;
        state_d = (op_q == OP_DUP) ? ST_PUSH_R : ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LIT;
      err_q   <= ERR_OK;
      idx_q   <= '0;
      depth_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= tok_op;
        idx_q <= TOK_IDX;
        a_q   <= TOK_DATA;
        err_q <= chk_err;
      end
      case (state_q)
        ST_POP_B: begin
          b_q     <= O_DATA;
          res_q   <= O_DATA;
          depth_q <= depth_q - 3'd1;
        end
        ST_POP_A: begin
          a_q     <= O_DATA;
          depth_q <= depth_q - 3'd1;
        end
        ST_GET: begin
          a_q   <= O_DATA;
          res_q <= O_DATA;
        end
        ST_PUSH_R, ST_PUSH_L: begin
          res_q   <= alu_res;
          depth_q <= depth_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Bench: sequencer against a behavioural 5-entry modulo-pointer stack, checked by a queue-based RPN model.
module tb_stack_rpn_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, TOK_VALID, TOK_READY, RES_VALID;
  logic [2:0] TOK_OP, TOK_IDX, INDEX, DEPTH_O;
  logic [3:0] TOK_DATA, I_DATA, O_DATA, RES_DATA;
  logic [1:0] COMMAND, ERR;

  always #5 CLK = ~CLK;

  stack_rpn_sequencer dut (
    .CLK(CLK), .RESET(RESET), .TOK_VALID(TOK_VALID), .TOK_READY(TOK_READY),
    .TOK_OP(TOK_OP), .TOK_DATA(TOK_DATA), .TOK_IDX(TOK_IDX), .COMMAND(COMMAND),
    .INDEX(INDEX), .I_DATA(I_DATA), .O_DATA(O_DATA), .RES_VALID(RES_VALID),
    .RES_DATA(RES_DATA), .ERR(ERR), .DEPTH_O(DEPTH_O)
  );

  // Stand-in for the structural stack: modulo-5 pointer, O_DATA valid during pop/get.
  logic [3:0] mem [5];
  int sp = 0;
  int push_cnt = 0, pop_cnt = 0, get_cnt = 0;

  always @(posedge CLK) begin
    if (RESET) sp <= 0;
    else begin
      case (COMMAND)
        2'b01: begin mem[sp] <= I_DATA; sp <= (sp + 1) % 5; push_cnt <= push_cnt + 1; end
        2'b10: begin sp <= (sp + 4) % 5; pop_cnt <= pop_cnt + 1; end
        2'b11: get_cnt <= get_cnt + 1;
        default: ;
      endcase
    end
  end

  always_comb begin
    O_DATA = 4'h0;
    if (COMMAND == 2'b10)      O_DATA = mem[(sp + 4) % 5];
    else if (COMMAND == 2'b11) O_DATA = mem[(sp + 9 - int'(INDEX)) % 5];
  end

  int n_cmp = 0, n_bad = 0;
  int ref_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // RPN semantics on a plain queue (back = top of stack).
  task automatic model(input int op, input int d, input int idx,
                       output int e_err, output int e_res, output int e_lat,
                       output int e_push, output int e_pop, output int e_get);
    int n, a, b, r;
    n = ref_q.size();
    e_err = 0; e_res = 0; e_lat = 0; e_push = 0; e_pop = 0; e_get = 0;
    case (op)
      0: if (n >= 5) e_err = 1;
         else begin ref_q.push_back(d); e_res = d; e_push = 1; e_lat = 2; end
      1, 2, 3, 4: if (n < 2) e_err = 2;
         else begin
           b = ref_q.pop_back();
           a = ref_q.pop_back();
           case (op)
`ifdef STACK_RPN_SAT_EN
             1: r = (a + b > 15) ? 15 : a + b;
             2: r = (a < b) ? 0 : a - b;
`else
             1: r = (a + b) % 16;
             2: r = (a - b + 16) % 16;
`endif
             3: r = a & b;
             default: r = a ^ b;
           endcase
           ref_q.push_back(r);
           e_res = r; e_push = 1; e_pop = 2; e_lat = 4;
         end
      5: if (n < 1) e_err = 2;
         else if (n >= 5) e_err = 1;
         else begin r = ref_q[n-1]; ref_q.push_back(r); e_res = r; e_get = 1; e_push = 1; e_lat = 3; end
      6: if (idx >= n) e_err = 3;
         else begin e_res = ref_q[n-1-idx]; e_get = 1; e_lat = 2; end
      default: if (n < 1) e_err = 2;
         else begin e_res = ref_q.pop_back(); e_pop = 1; e_lat = 2; end
    endcase
    if (e_err != 0) e_lat = 1;
  endtask

  // Called and returns at a falling edge with the DUT idle, so tokens run back to back.
  task automatic do_token(input int op, input int d, input int idx,
                          output logic [3:0] r_data, output logic [1:0] r_err);
    int e_err, e_res, e_lat, e_push, e_pop, e_get;
    int p0, q0, g0, lat;
    bit seen;
    model(op, d, idx, e_err, e_res, e_lat, e_push, e_pop, e_get);
    check("tok_ready", TOK_READY, 1);
    p0 = push_cnt; q0 = pop_cnt; g0 = get_cnt;
    TOK_VALID = 1'b1; TOK_OP = 3'(op); TOK_DATA = 4'(d); TOK_IDX = 3'(idx);
    @(negedge CLK);
    TOK_VALID = 1'b0;
    lat = 1; seen = 0;
    while (!seen && lat <= 8) begin
      if (RES_VALID) seen = 1;
      else begin @(negedge CLK); lat++; end
    end
    check("res_valid_seen", seen, 1);
    r_data = RES_DATA; r_err = ERR;
    if (seen) begin
      check("latency", lat, e_lat);
      check("err", ERR, e_err);
      if (e_err == 0) check("res_data", RES_DATA, e_res);
      check("depth", DEPTH_O, ref_q.size());
      check("push_cmds", push_cnt - p0, e_push);
      check("pop_cmds", pop_cnt - q0, e_pop);
      check("get_cmds", get_cnt - g0, e_get);
      @(negedge CLK);
      check("res_valid_pulse", RES_VALID, 0);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    ref_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_command"}, COMMAND, 0);
    check({tag, "_index"}, INDEX, 0);
    check({tag, "_i_data"}, I_DATA, 0);
    check({tag, "_res_valid"}, RES_VALID, 0);
    check({tag, "_res_data"}, RES_DATA, 0);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_depth"}, DEPTH_O, 0);
    check({tag, "_tok_ready"}, TOK_READY, 1);
  endtask

  initial begin
    logic [3:0] rd;
    logic [1:0] re;
    int p0, op;
    RESET = 1'b1; TOK_VALID = 1'b0; TOK_OP = '0; TOK_DATA = '0; TOK_IDX = '0;
    @(negedge CLK);
    check_reset_vals("rst");
    RESET = 1'b0;
    @(negedge CLK);

    // 1: 3 + 9
    do_reset();
    do_token(0, 3, 0, rd, re);
    do_token(0, 9, 0, rd, re);
    do_token(1, 0, 0, rd, re);
    check("t1_sum", rd, 12);
    check("t1_err", re, 0);
    check("t1_depth", DEPTH_O, 1);

    // 2: 2 - 5
    do_reset();
    do_token(0, 2, 0, rd, re);
    do_token(0, 5, 0, rd, re);
    do_token(2, 0, 0, rd, re);
`ifdef STACK_RPN_SAT_EN
    check("t2_sub", rd, 0);
`else
    check("t2_sub", rd, 13);
`endif

    // 3: fill, overflow, deepest peek
    do_reset();
    for (int i = 1; i <= 5; i++) do_token(0, i, 0, rd, re);
    check("t3_full", DEPTH_O, 5);
    do_token(0, 6, 0, rd, re);
    check("t3_overflow", re, 1);
    check("t3_depth_held", DEPTH_O, 5);
    do_token(6, 0, 4, rd, re);
    check("t3_peek4", rd, 1);

    // 4: underflow from empty
    do_reset();
    do_token(1, 0, 0, rd, re);
    check("t4_add_under", re, 2);
    check("t4_depth", DEPTH_O, 0);
    do_token(7, 0, 0, rd, re);
    check("t4_drop_under", re, 2);

    // 5: dup, peek, bad index
    do_reset();
    do_token(0, 7, 0, rd, re);
    do_token(5, 0, 0, rd, re);
    do_token(6, 0, 1, rd, re);
    check("t5_peek1", rd, 7);
    check("t5_depth", DEPTH_O, 2);
    do_token(6, 0, 2, rd, re);
    check("t5_bad_idx", re, 3);

    // 6: reset while the second operand of an XOR is being popped
    do_reset();
    do_token(0, 1, 0, rd, re);
    do_token(0, 2, 0, rd, re);
    p0 = push_cnt;
    TOK_VALID = 1'b1; TOK_OP = 3'd4;
    @(negedge CLK);
    TOK_VALID = 1'b0;
    check("t6_pop_b", COMMAND, 2);
    @(negedge CLK);
    check("t6_pop_a", COMMAND, 2);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    ref_q.delete();
    check_reset_vals("t6");
    repeat (4) @(negedge CLK);
    check("t6_no_push", push_cnt - p0, 0);
    check("t6_depth_after", DEPTH_O, 0);

    // Random token stream, LIT-biased so the stack exercises its full range
    do_reset();
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 7));
      do_token(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 5)), rd, re);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
